// File: rtl/lb_master_bridge.sv
// ---------------------------------------------------------------------------
// lb_master_bridge
//
// Local-bus initiator. Accepts one host command at a time on a valid/ready
// channel, issues a single-cycle lb read or write strobe, waits for the
// matching ack (or a timeout), then presents the result on a valid/ready
// response channel.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_wr/cmd_addr/cmd_wdata command fields (wdata ignored for reads)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         read data (DEFAULT_DATA_VAL for writes and
//                             timeouts) and timeout flag
//   lb_wr_en/lb_rd_en         single-cycle strobes to the slave
//   lb_addr/lb_wr_data        held from the strobe until ack or timeout
//   lb_wr_valid/lb_rd_valid   acks from the slave; lb_rd_valid qualifies
//   lb_rd_data                read data from the slave
//   busy                      high whenever the bridge is not idle
// ---------------------------------------------------------------------------
module lb_master_bridge #(
  parameter int                   LB_DATA_W        = 32,
  parameter int                   LB_ADDR_W        = 16,
  parameter int                   TIMEOUT_CYCLES   = 256,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [LB_ADDR_W-1:0] cmd_addr,
  input  logic [LB_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [LB_DATA_W-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 lb_wr_en,
  output logic                 lb_rd_en,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [LB_DATA_W-1:0] lb_wr_data,
  input  logic                 lb_wr_valid,
  input  logic                 lb_rd_valid,
  input  logic [LB_DATA_W-1:0] lb_rd_data,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state, state_nxt;
  logic                 wr_q;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic                 ack;
  logic                 load_cmd;
  logic                 load_rsp;
  logic [LB_DATA_W-1:0] rdata_nxt;
  logic                 err_nxt;

  // Only the ack matching the outstanding command type counts.
  assign ack     = wr_q ? lb_wr_valid : lb_rd_valid;
  // Saturating increment: the counter never wraps back into range.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_cmd  = 1'b0;
    load_rsp  = 1'b0;
    rdata_nxt = DEFAULT_DATA_VAL;
    err_nxt   = 1'b0;
    cmd_ready = 1'b0;
    lb_wr_en  = 1'b0;
    lb_rd_en  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        // Ready is withheld while reset is held, even though state is IDLE.
        cmd_ready = ~rst;
        if (cmd_valid && cmd_ready) begin
          load_cmd  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        lb_wr_en = wr_q;
        lb_rd_en = ~wr_q;
        cnt_nxt  = '0;
        if (ack) begin
          load_rsp  = 1'b1;
          rdata_nxt = wr_q ? DEFAULT_DATA_VAL : lb_rd_data;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_nxt = cnt_inc;
        // An ack in the expiry cycle takes priority over the timeout.
        if (ack) begin
          load_rsp  = 1'b1;
          rdata_nxt = wr_q ? DEFAULT_DATA_VAL : lb_rd_data;
          state_nxt = S_RESP;
        end else if (cnt_inc == CNT_LAST) begin
          load_rsp  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      lb_addr    <= '0;
      lb_wr_data <= '0;
      rsp_rdata  <= DEFAULT_DATA_VAL;
      rsp_err    <= 1'b0;
    end else begin
      if (load_cmd) begin
        wr_q       <= cmd_wr;
        lb_addr    <= cmd_addr;
        lb_wr_data <= cmd_wdata;
      end
      // Response fields change only on entry to RESP, so they hold through
      // any amount of backpressure and ignore stray acks.
      if (load_rsp) begin
        rsp_rdata <= rdata_nxt;
        rsp_err   <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_lb_master_bridge
//
// Self-checking bench for lb_master_bridge with TIMEOUT_CYCLES=16. The bench
// plays host and slave: a table of directed transactions (with hand-written
// expectations) followed by random transactions whose expectations come from
// a transaction-level model, then an asynchronous reset in the middle of a
// wait. Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_lb_master_bridge;

  localparam int          DW  = 32;
  localparam int          AW  = 16;
  localparam int          TO  = 16;
  localparam logic [31:0] DEF = 32'hdeadbabe;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          lb_wr_en;
  logic          lb_rd_en;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_wr_data;
  logic          lb_wr_valid;
  logic          lb_rd_valid;
  logic [DW-1:0] lb_rd_data;
  logic          busy;

  lb_master_bridge #(
    .LB_DATA_W       (DW),
    .LB_ADDR_W       (AW),
    .TIMEOUT_CYCLES  (TO),
    .DEFAULT_DATA_VAL(DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .lb_wr_en   (lb_wr_en),
    .lb_rd_en   (lb_rd_en),
    .lb_addr    (lb_addr),
    .lb_wr_data (lb_wr_data),
    .lb_wr_valid(lb_wr_valid),
    .lb_rd_valid(lb_rd_valid),
    .lb_rd_data (lb_rd_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ack_delay: cycles after the strobe at which the slave acks (0 = same
  // cycle); negative means the slave never answers.
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    logic [31:0] rdata;
    int          rsp_wait;
    bit          hold_cmd;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // Transaction-level model: an ack within the first TO cycles after the
  // strobe (index 0..TO-1) answers one cycle later; otherwise the response
  // is a timeout TO cycles after the strobe.
  function automatic void model(input vec_t v, output int lat, output bit err,
                                output logic [31:0] data);
    if (v.ack_delay >= 0 && v.ack_delay < TO) begin
      lat  = v.ack_delay + 1;
      err  = 1'b0;
      data = v.wr ? DEF : v.rdata;
    end else begin
      lat  = TO;
      err  = 1'b1;
      data = DEF;
    end
  endfunction

  // Called on a falling edge with the bridge idle; returns on a falling edge
  // with the bridge idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int          lat;
    bit          seen;
    int          pulses;
    bit          strobe_ok;
    bit          hold_ok;
    bit          stable;
    logic        match;
    logic [31:0] snap_d;
    logic        snap_e;

    cmd_valid = 1'b1;
    cmd_wr    = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;

    pulses = 0; strobe_ok = 1'b1; hold_ok = 1'b1; seen = 1'b0; lat = -1;
    for (int c = 0; c <= TO + 4; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      if (lb_wr_en || lb_rd_en) begin
        pulses++;
        if (c != 0 || lb_wr_en !== v.wr || lb_rd_en !== !v.wr) strobe_ok = 1'b0;
      end
      if (lb_addr !== v.addr || (v.wr && lb_wr_data !== v.wdata)) hold_ok = 1'b0;
      // Matching ack only at the chosen cycle; the other ack type toggles
      // randomly and must be ignored.
      match = (c == v.ack_delay);
      if (v.wr) begin
        lb_wr_valid = match;
        lb_rd_valid = 1'($urandom);
      end else begin
        lb_rd_valid = match;
        lb_wr_valid = 1'($urandom);
      end
      lb_rd_data = match ? v.rdata : $urandom;
      @(negedge clk);
    end
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;

    check({tag, " rsp_seen"}, 64'(seen), 64'(1));
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    check({tag, " strobe_pulses"}, 64'(pulses), 64'(1));
    check({tag, " strobe_kind"}, 64'(strobe_ok), 64'(1));
    check({tag, " addr_data_hold"}, 64'(hold_ok), 64'(1));

    // Backpressure: stray acks of both kinds must not disturb the response.
    snap_d = rsp_rdata;
    snap_e = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < v.rsp_wait; i++) begin
      rsp_ready   = 1'b0;
      lb_wr_valid = 1'($urandom);
      lb_rd_valid = 1'($urandom);
      lb_rd_data  = $urandom;
      if (v.hold_cmd) begin
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 16'h3000;
      end
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap_d || rsp_err !== snap_e ||
          cmd_ready !== 1'b0 || lb_wr_en !== 1'b0 || lb_rd_en !== 1'b0) stable = 1'b0;
    end
    if (v.rsp_wait > 0) check({tag, " rsp_stable"}, 64'(stable), 64'(1));

    rsp_ready   = 1'b1;
    lb_wr_valid = 1'($urandom);
    lb_rd_valid = 1'($urandom);
    @(negedge clk);
    rsp_ready   = 1'b0;
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    // Even with a command held, the handshake edge itself must not accept it.
    check({tag, " idle_after_rsp"}, 64'({rsp_valid, busy, cmd_ready}), 64'(3'b001));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs[10];
  vec_t rv;
  int   r_lat;
  bit   r_err;
  logic [31:0] r_data;
  bit   quiet;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; lb_wr_valid = 1'b0; lb_rd_valid = 1'b0; lb_rd_data = '0;

    // Reset values while rst is held.
    #2;
    check("rst cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst rsp_valid/err", 64'({rsp_valid, rsp_err}), 64'(0));
    check("rst rsp_rdata", 64'(rsp_rdata), 64'(DEF));
    check("rst strobes/busy", 64'({lb_wr_en, lb_rd_en, busy}), 64'(0));
    check("rst lb_addr", 64'(lb_addr), 64'(0));
    check("rst lb_wr_data", 64'(lb_wr_data), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle cmd_ready", 64'(cmd_ready), 64'(1));

    vecs[0] = '{wr:0, addr:16'h1004, wdata:32'h0, ack_delay:3, rdata:32'h1234_5678,
                rsp_wait:0, hold_cmd:0, exp_lat:4, exp_err:0, exp_rdata:32'h1234_5678};
    vecs[1] = '{wr:1, addr:16'h2000, wdata:32'hcafe_f00d, ack_delay:0, rdata:32'h1111_2222,
                rsp_wait:0, hold_cmd:0, exp_lat:1, exp_err:0, exp_rdata:32'hdead_babe};
    vecs[2] = '{wr:0, addr:16'h1010, wdata:32'h0, ack_delay:-1, rdata:32'h0,
                rsp_wait:8, hold_cmd:0, exp_lat:16, exp_err:1, exp_rdata:32'hdead_babe};
    vecs[3] = '{wr:0, addr:16'h1020, wdata:32'h0, ack_delay:15, rdata:32'ha5a5_0f0f,
                rsp_wait:2, hold_cmd:0, exp_lat:16, exp_err:0, exp_rdata:32'ha5a5_0f0f};
    vecs[4] = '{wr:1, addr:16'h2004, wdata:32'h0bad_f00d, ack_delay:15, rdata:32'h5555_aaaa,
                rsp_wait:0, hold_cmd:0, exp_lat:16, exp_err:0, exp_rdata:32'hdead_babe};
    vecs[5] = '{wr:1, addr:16'h2008, wdata:32'h0000_0042, ack_delay:-1, rdata:32'h0,
                rsp_wait:1, hold_cmd:0, exp_lat:16, exp_err:1, exp_rdata:32'hdead_babe};
    vecs[6] = '{wr:0, addr:16'h1030, wdata:32'h0, ack_delay:0, rdata:32'h0000_0001,
                rsp_wait:0, hold_cmd:0, exp_lat:1, exp_err:0, exp_rdata:32'h0000_0001};
    vecs[7] = '{wr:0, addr:16'h1040, wdata:32'h0, ack_delay:1, rdata:32'hfeed_beef,
                rsp_wait:10, hold_cmd:1, exp_lat:2, exp_err:0, exp_rdata:32'hfeed_beef};
    vecs[8] = '{wr:0, addr:16'h3000, wdata:32'h0, ack_delay:2, rdata:32'h3000_3000,
                rsp_wait:0, hold_cmd:0, exp_lat:3, exp_err:0, exp_rdata:32'h3000_3000};
    vecs[9] = '{wr:1, addr:16'hfffe, wdata:32'hffff_ffff, ack_delay:14, rdata:32'h0,
                rsp_wait:0, hold_cmd:0, exp_lat:15, exp_err:0, exp_rdata:32'hdead_babe};

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rv.wr        = 1'($urandom);
      rv.addr      = 16'($urandom);
      rv.wdata     = $urandom;
      rv.rdata     = $urandom;
      rv.ack_delay = (r == 0) ? -1 : (r < 3) ? int'($urandom_range(13, 20))
                                             : int'($urandom_range(0, 6));
      rv.rsp_wait  = int'($urandom_range(0, 3));
      rv.hold_cmd  = 1'b0;
      model(rv, r_lat, r_err, r_data);
      rv.exp_lat   = r_lat;
      rv.exp_err   = r_err;
      rv.exp_rdata = r_data;
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a wait with no ack coming.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h4444; cmd_wdata = 32'h4444_4444;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid strobe", 64'(lb_rd_en), 64'(1));
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst strobes/rsp/busy", 64'({lb_wr_en, lb_rd_en, rsp_valid, busy}), 64'(0));
    check("mid_rst cmd_ready", 64'(cmd_ready), 64'(0));
    check("mid_rst lb_addr", 64'(lb_addr), 64'(0));
    check("mid_rst rsp fields", 64'({rsp_err, rsp_rdata}), 64'({1'b0, DEF}));
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lb_wr_valid = 1'b1;
      lb_rd_valid = 1'b1;
      lb_rd_data  = $urandom;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b1 & 1'b0;
    end
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    check("post_rst stray acks ignored", 64'(quiet), 64'(1));

    rv = '{wr:0, addr:16'h5008, wdata:32'h0, ack_delay:2, rdata:32'h0ddc_0ffe,
           rsp_wait:1, hold_cmd:0, exp_lat:0, exp_err:0, exp_rdata:32'h0};
    model(rv, r_lat, r_err, r_data);
    rv.exp_lat   = r_lat;
    rv.exp_err   = r_err;
    rv.exp_rdata = r_data;
    run_txn(rv, "post_rst_read");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
